score_digit_encoder: RTL
========================

SCORE_DIGIT_ENCODER -- requirements
Module: score_digit_encoder

Interface
REQ-001 SHALL have parameter BIN_W, default 7, meaning binary score width (legal 1..30).
REQ-002 SHALL have parameter DIGITS, default 2, meaning decimal digits displayed (legal 1..9).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request conversion of score, sampled on clk edges.
REQ-006 SHALL have port score  input  BIN_W  unsigned binary value to convert.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when new onehot/overflow are valid.
REQ-009 SHALL have port onehot  output  10*DIGITS  digit k occupies bits [10k+9:10k], digit 0 = ones; bit n set means value n.
REQ-010 SHALL have port overflow  output  1  high when last converted score > 10^DIGITS-1.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-012 In IDLE with start=1 at edge N, SHALL latch score, clear internal BCD (DIGITS x 4 bits), load shift count BIN_W, latch overflow flag = (score > 10^DIGITS-1), go to SHIFT.
REQ-013 In SHIFT, each edge SHALL add 3 to every BCD digit >= 5, then shift {BCD, binary} left one bit; after BIN_W such edges (N+1..N+BIN_W) go to DONE.
REQ-014 In DONE (edge N+BIN_W+1) SHALL register onehot, overflow, assert done for exactly one cycle, return to IDLE.
REQ-015 Latency SHALL be BIN_W+1 cycles from start-sampling edge to outputs/done visible; default 8 cycles.
REQ-016 If the latched overflow flag is set, every digit SHALL display 9 and overflow SHALL be 1; BCD bits above DIGITS digits are discarded.
REQ-017 start while busy=1 SHALL be ignored with no effect on the running conversion.
REQ-018 start asserted in the done cycle (state IDLE) SHALL be accepted, giving back-to-back conversions every BIN_W+2 cycles.
REQ-019 score changes after the sampling edge SHALL not affect the running conversion.
REQ-020 onehot and overflow SHALL hold their last values between DONE updates; each digit field SHALL have exactly one bit set except as REQ-025 allows.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, busy 0, done 0, overflow 0, shift count 0, internal BCD 0.
REQ-022 rst_n low SHALL set onehot to every digit showing 0 (bit 10k set), subject to REQ-025.
REQ-023 Reset mid-conversion SHALL abort it with no done pulse; first start after rst_n rises restarts cleanly.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-025 With LEADING_ZERO_BLANK_EN defined, every digit k>=1 that is 0 with all higher digits 0 SHALL output an all-zero field; digit 0 always shows; reset applies the same rule (only bit 0 set).
REQ-026 Without LEADING_ZERO_BLANK_EN, every digit SHALL always output exactly one set bit.

Verification (defaults BIN_W=7, DIGITS=2, macro undefined unless stated)
REQ-027 score=0, start pulse -> done 8 cycles later, onehot ones=bit0, tens=bit10, overflow=0.
REQ-028 score=99 -> ones bit9, tens bit19, overflow=0; score=47 -> bits 7 and 14 set; busy high 8 cycles.
REQ-029 score=100 and score=127 -> both digits show 9 (bits 9,19), overflow=1; subsequent score=5 clears overflow.
REQ-030 start=1 held continuously with score=42 then 43 at cycle 3 -> first result 42, conversions every 9 cycles, mid-conversion start ignored.
REQ-031 rst_n low at cycle 4 of conversion -> no done, onehot reset value, busy 0; next start converts correctly.
REQ-032 LEADING_ZERO_BLANK_EN defined, score=7 -> ones bit7, tens field 0; score=70 -> bits 0 and 17; reset -> only bit0.

Source files
------------

// File: rtl/score_digit_encoder.sv
// Converts a binary score to per-digit one-hot decimal fields using shift-add-3 (double dabble).
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above the ones digit.
module score_digit_encoder #(
   parameter int unsigned BIN_W  = 7,
   parameter int unsigned DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      score,
   output logic                  busy,
   output logic                  done,
   output logic [10*DIGITS-1:0]  onehot,
   output logic                  overflow
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned OH_W  = 10 * DIGITS;

   function automatic longint unsigned max_display();
      longint unsigned v;
      v = 1;
      for (int i = 0; i < int'(DIGITS); i++) v = v * 10;
      return v - 1;
   endfunction

   function automatic logic [OH_W-1:0] reset_onehot();
      logic [OH_W-1:0] v;
      v = '0;
`ifdef LEADING_ZERO_BLANK_EN
      v[0] = 1'b1;
`else
      for (int k = 0; k < int'(DIGITS); k++) v[10*k] = 1'b1;
`endif
      return v;
   endfunction

   localparam longint unsigned MAX_VAL    = max_display();
   localparam logic [OH_W-1:0] ONEHOT_RST = reset_onehot();

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e                 r_state, w_state_d;
   logic [BIN_W-1:0]       r_bin, w_bin_d;
   logic [BCD_W-1:0]       r_bcd, w_bcd_d, w_bcd_adj;
   logic [CNT_W-1:0]       r_cnt, w_cnt_d;
   logic                   r_ovf_lat, w_ovf_lat_d;
   logic                   r_done, w_done_d;
   logic                   r_overflow, w_overflow_d;
   logic [OH_W-1:0]        r_onehot, w_onehot_d, w_onehot_dec;
   logic [BCD_W+BIN_W-1:0] w_shifted;
   logic [3:0]             w_digit;
   logic                   w_score_ovf;
`ifdef LEADING_ZERO_BLANK_EN
   logic                   w_lead;
`endif

   assign w_score_ovf = 64'(score) > MAX_VAL;

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
   end

   // BCD bits shifted out of the top digit are dropped; overflow forces all 9s anyway.
   assign w_shifted = {w_bcd_adj, r_bin} << 1;

   always_comb begin
      w_onehot_dec = '0;
      w_digit      = '0;
`ifdef LEADING_ZERO_BLANK_EN
      w_lead       = 1'b1;
`endif
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         w_digit = r_ovf_lat ? 4'd9 : r_bcd[4*k +: 4];
         w_onehot_dec[10*k +: 10] = 10'd1 << w_digit;
`ifdef LEADING_ZERO_BLANK_EN
         if (k != 0 && w_lead && w_digit == 4'd0) w_onehot_dec[10*k +: 10] = '0;
         if (w_digit != 4'd0) w_lead = 1'b0;
`endif
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_bin_d      = r_bin;
      w_bcd_d      = r_bcd;
      w_cnt_d      = r_cnt;
      w_ovf_lat_d  = r_ovf_lat;
      w_done_d     = 1'b0;
      w_overflow_d = r_overflow;
      w_onehot_d   = r_onehot;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_bin_d     = score;
               w_bcd_d     = '0;
               w_cnt_d     = CNT_W'(BIN_W);
               w_ovf_lat_d = w_score_ovf;
               w_state_d   = StShift;
            end
         end
         StShift: begin
            w_bin_d = w_shifted[BIN_W-1:0];
            w_bcd_d = w_shifted[BIN_W +: BCD_W];
            w_cnt_d = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) w_state_d = StDone;
         end
         StDone: begin
            w_onehot_d   = w_onehot_dec;
            w_overflow_d = r_ovf_lat;
            w_done_d     = 1'b1;
            w_state_d    = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_ovf_lat  <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_onehot   <= ONEHOT_RST;
      end else begin
         r_state    <= w_state_d;
         r_bin      <= w_bin_d;
         r_bcd      <= w_bcd_d;
         r_cnt      <= w_cnt_d;
         r_ovf_lat  <= w_ovf_lat_d;
         r_done     <= w_done_d;
         r_overflow <= w_overflow_d;
         r_onehot   <= w_onehot_d;
      end
   end

   assign busy     = (r_state != StIdle);
   assign done     = r_done;
   assign onehot   = r_onehot;
   assign overflow = r_overflow;

endmodule
